sc_rr_encoder: RTL
==================

# sc_rr_encoder

Sequential round-robin encoder: the inverse path of the 6-to-38 one-hot register-select decoder in the microdatapath. It accumulates a multi-hot 38-bit request vector (one bit per register or source) and reports one pending bit at a time as a 6-bit binary index, using a valid/ack handshake. Arbitration is round-robin, so no source starves. Its output index feeds the register-select decoder, or any consumer that needs a binary register number.

## Interface
- DATAWIDTH_ENCODER_IN, 38: number of request lines.
- DATAWIDTH_ENCODER_OUT, 6: index width, ceil(log2(DATAWIDTH_ENCODER_IN)).
- SC_RRENCODER_CLOCK_50  input  1: single clock, rising edge.
- SC_RRENCODER_RESET_InLow  input  1: reset, asynchronous assert, active-low.
- SC_RRENCODER_Request_In  input  38: multi-hot request vector, sampled only when Load_In=1.
- SC_RRENCODER_Load_In  input  1: OR Request_In into the pending set.
- SC_RRENCODER_Ack_In  input  1: consumer accepts the current index.
- SC_RRENCODER_Index_Out  output  6: binary index of the granted request, registered.
- SC_RRENCODER_Valid_Out  output  1: Index_Out is valid, registered.
- SC_RRENCODER_PendingCount_Out  output  6: number of set bits in the pending set, registered.

## Operation
- State: pending register P[37:0]; last-grant pointer L[5:0]; output registers.
- FSM has two states:
  - IDLE: P==0 after update, Valid_Out=0.
  - GRANT: Valid_Out=1.
- Transitions:
  - IDLE→GRANT when the next P is nonzero.
  - GRANT→IDLE when Ack_In=1 and the next P is zero.
  - Otherwise stay.
- P update each cycle:
  - P_next = (P & ~clr) | (Load_In ? Request_In : 0).
  - clr is one-hot of Index_Out when Valid_Out&&Ack_In, else 0.
- Simultaneous ack and load of the same bit: the bit stays set and is re-queued behind the others.
- Selection (pick): search P_next starting at index L+1 (or L_next+1 after an ack), ascending to 37, then wrapping to 0 through L.
  - The first set bit wins.
  - Wrap is at 37, not 63.
  - Indices 38..63 are never produced.
- Selection is recomputed only when Valid_Out=0, or Valid_Out=1 with Ack_In=1.
- While Valid_Out=1 and Ack_In=0, Index_Out holds stable even if Load_In adds requests.
- On ack: L <= Index_Out.
- Ack_In while Valid_Out=0 is ignored.
- Load_In with Request_In==0 has no effect.
- PendingCount_Out = popcount(P_next), registered. Range 0..38.
- Reset values:
  - P=0, L=37 (so the first search starts at index 0).
  - Index_Out=0, Valid_Out=0, PendingCount_Out=0, state IDLE.
- Reset asserted mid-operation clears everything immediately. Pending requests are lost.

## Timing
- Load at edge t → Valid_Out=1, Index_Out, and PendingCount_Out updated after edge t+1 (1-cycle latency).
- Ack at edge t with remaining requests → new Index_Out after edge t+1, Valid_Out stays 1. Throughput is one grant per cycle.
- Ack at edge t on the last request → Valid_Out=0 after edge t+1.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset deassertion is synchronized externally. The block requires a clean release relative to the clock.

## Structure
- Shared package holds:
  - ENCODER_NUM_SOURCES=38 and ENCODER_INDEX_WIDTH=6, shared with the 6-to-38 decoder.
  - The state encoding (STATE_IDLE=1'b0, STATE_GRANT=1'b1).
- One combinational sub-module, sc_rr_encoder_pick:
  - Inputs: vector[37:0], start pointer[5:0].
  - Outputs: index[5:0], found.
  - Implements the wrap-at-37 rotating priority search.
- Popcount is a function in the package.

## Test plan
- Reset, then Load with Request=0x00_0000_0005 → next cycle Index=0, Valid=1, Count=2; ack → Index=2, Count=1; ack → Valid=0, Count=0.
- Request bits 37 and 0, with L forced to 36 by granting 36 first → order is 37, then 0 (wrap at 37, never 38..63).
- Hold Ack=0 for 5 cycles while loading bit 3 under a current grant of index 10 → Index stays 10; ack → Index=3 only after the wrap, i.e. bits above 10 are served first.
- Ack plus Load of the same bit 5 in the same cycle with only bit 5 pending → Valid remains 1, Index=5 again, Count=1.
- All 38 bits loaded → 38 consecutive acked cycles yield indices 0..37 in order, Count decrements 38→0, then Valid=0.
- Assert reset mid-stream with Count=20 → all outputs go to 0 asynchronously; after release, Ack is ignored and Valid stays 0.

Source files
------------

// File: rtl/sc_rr_encoder_pkg.sv
// Shared constants, FSM encoding and popcount helper for the round-robin encoder
// (source/index widths are shared with the 6-to-38 register-select decoder).
package sc_rr_encoder_pkg;

  localparam int ENCODER_NUM_SOURCES = 38;
  localparam int ENCODER_INDEX_WIDTH = 6;

  typedef enum logic {
    STATE_IDLE  = 1'b0,
    STATE_GRANT = 1'b1
  } state_e;

  function automatic logic [ENCODER_INDEX_WIDTH-1:0] popcount(
    input logic [ENCODER_NUM_SOURCES-1:0] v
  );
    logic [ENCODER_INDEX_WIDTH-1:0] cnt;
    logic [ENCODER_NUM_SOURCES-1:0] tmp;
    cnt = '0;
    tmp = v;
    for (int i = 0; i < ENCODER_NUM_SOURCES; i++) begin
      cnt = cnt + {{(ENCODER_INDEX_WIDTH-1){1'b0}}, tmp[0]};
      tmp = tmp >> 1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sc_rr_encoder_pick.sv
// Rotating-priority search: first set bit at or after start_i, ascending,
// wrapping from N-1 back to 0 (never visits indices N..2**W-1).
module sc_rr_encoder_pick #(
  parameter int N = 38,
  parameter int W = 6
) (
  input  logic [N-1:0] vector_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] index_o,
  output logic         found_o
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  logic [W-1:0] pos;

  always_comb begin
    index_o = '0;
    found_o = 1'b0;
    pos     = start_i;
    for (int k = 0; k < N; k++) begin
      if (!found_o && vector_i[pos]) begin
        found_o = 1'b1;
        index_o = pos;
      end
      pos = (pos == LAST_IDX) ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/sc_rr_encoder.sv
// Sequential round-robin encoder: accumulates a multi-hot request set and hands
// out one pending index per valid/ack transfer, resuming after the last grant.
module sc_rr_encoder
  import sc_rr_encoder_pkg::*;
#(
  parameter int DATAWIDTH_ENCODER_IN  = ENCODER_NUM_SOURCES,
  parameter int DATAWIDTH_ENCODER_OUT = ENCODER_INDEX_WIDTH
) (
  input  logic                             SC_RRENCODER_CLOCK_50,
  input  logic                             SC_RRENCODER_RESET_InLow,
  input  logic [DATAWIDTH_ENCODER_IN-1:0]  SC_RRENCODER_Request_In,
  input  logic                             SC_RRENCODER_Load_In,
  input  logic                             SC_RRENCODER_Ack_In,
  output logic [DATAWIDTH_ENCODER_OUT-1:0] SC_RRENCODER_Index_Out,
  output logic                             SC_RRENCODER_Valid_Out,
  output logic [DATAWIDTH_ENCODER_OUT-1:0] SC_RRENCODER_PendingCount_Out
);

  localparam logic [DATAWIDTH_ENCODER_OUT-1:0] LAST_IDX =
    DATAWIDTH_ENCODER_OUT'(DATAWIDTH_ENCODER_IN - 1);

  state_e                           state_q, state_d;
  logic [DATAWIDTH_ENCODER_IN-1:0]  pend_q, pend_d;
  logic [DATAWIDTH_ENCODER_OUT-1:0] last_q, last_d;
  logic [DATAWIDTH_ENCODER_OUT-1:0] idx_q, idx_d;
  logic [DATAWIDTH_ENCODER_OUT-1:0] cnt_q, cnt_d;

  logic                             ack_eff;
  logic [DATAWIDTH_ENCODER_IN-1:0]  clr;
  logic [DATAWIDTH_ENCODER_OUT-1:0] start;
  logic [DATAWIDTH_ENCODER_OUT-1:0] pick_idx;
  logic                             pick_found;

  sc_rr_encoder_pick #(
    .N (DATAWIDTH_ENCODER_IN),
    .W (DATAWIDTH_ENCODER_OUT)
  ) u_pick (
    .vector_i (pend_d),
    .start_i  (start),
    .index_o  (pick_idx),
    .found_o  (pick_found)
  );

  always_ff @(posedge SC_RRENCODER_CLOCK_50 or negedge SC_RRENCODER_RESET_InLow) begin
    if (!SC_RRENCODER_RESET_InLow) begin
      state_q <= STATE_IDLE;
      pend_q  <= '0;
      last_q  <= LAST_IDX;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ack_eff = (state_q == STATE_GRANT) && SC_RRENCODER_Ack_In;
    clr     = '0;
    if (ack_eff) clr[idx_q] = 1'b1;
    // A bit acked and reloaded in the same cycle survives; since the search
    // restarts just past it, it lands behind every other pending source.
    pend_d  = (pend_q & ~clr) | (SC_RRENCODER_Load_In ? SC_RRENCODER_Request_In : '0);
    last_d  = ack_eff ? idx_q : last_q;
    start   = (last_d >= LAST_IDX) ? '0 : last_d + 1'b1;

    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      STATE_IDLE: begin
        if (pick_found) begin
          state_d = STATE_GRANT;
          idx_d   = pick_idx;
        end
      end
      STATE_GRANT: begin
        // Without an ack the granted index is frozen, whatever gets loaded.
        if (SC_RRENCODER_Ack_In) begin
          if (pick_found) idx_d = pick_idx;
          else            state_d = STATE_IDLE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
    cnt_d = popcount(pend_d);
  end

  assign SC_RRENCODER_Index_Out        = idx_q;
  assign SC_RRENCODER_Valid_Out        = (state_q == STATE_GRANT);
  assign SC_RRENCODER_PendingCount_Out = cnt_q;

endmodule
